// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing defaults, decoder state type and a small saturating helper
// shared by the VGA sync decoder slice.
package vga_timing_pkg;

  localparam int unsigned COORD_W          = 10;
  localparam int unsigned H_TOTAL_DEF      = 800;
  localparam int unsigned H_ACTIVE_DEF     = 640;
  localparam int unsigned H_SYNC_START_DEF = 656;
  localparam int unsigned H_SYNC_LEN_DEF   = 96;
  localparam int unsigned V_TOTAL_DEF      = 525;
  localparam int unsigned V_ACTIVE_DEF     = 480;
  localparam int unsigned V_SYNC_START_DEF = 490;
  localparam int unsigned V_SYNC_LEN_DEF   = 2;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } sync_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// VGA output bus as seen by the decoder: pixel strobe plus the sampled sync/blank lines.
interface vga_sync_decoder_if;
  logic pix_en;
  logic hs;
  logic vs;
  logic blank;

  modport master (output pix_en, hs, vs, blank);
  modport slave  (input  pix_en, hs, vs, blank);
endinterface

// File: rtl/sync_edge.sv
// Strobe-qualified edge detector for one active-low sync line.
module sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic pix_en,
  input  logic in,
  output logic fall,
  output logic rise
);

  logic prev;

  // Idle level of a sync line is high, so reset there to avoid a phantom rise.
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      prev <= 1'b1;
    else if (pix_en)
      prev <= in;
  end

  assign fall = pix_en &  prev & ~in;
  assign rise = pix_en & ~prev &  in;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates from hs/vs/blank, verifies sync timing and tracks lock/errors.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  vga_sync_decoder_if.slave    bus,
  output logic [COORD_W-1:0]   RxX,
  output logic [COORD_W-1:0]   RxY,
  output logic                 active,
  output logic                 frame_start,
  output logic                 locked,
  output logic                 sync_err,
  output logic                 blank_err,
  output logic [7:0]           err_count
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_F   = COORD_W'(H_SYNC_START);
  localparam logic [COORD_W-1:0] HS_R   = COORD_W'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [COORD_W-1:0] VS_F   = COORD_W'(V_SYNC_START);
  localparam logic [COORD_W-1:0] VS_R   = COORD_W'(V_SYNC_START + V_SYNC_LEN);

  logic hs_fall, hs_rise, vs_fall, vs_rise;

  sync_edge u_hs_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .pix_en  (bus.pix_en),
    .in      (bus.hs),
    .fall    (hs_fall),
    .rise    (hs_rise)
  );

  sync_edge u_vs_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .pix_en  (bus.pix_en),
    .in      (bus.vs),
    .fall    (vs_fall),
    .rise    (vs_rise)
  );

  sync_state_t        state, state_nxt;
  logic [COORD_W-1:0] x, y;
  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic               in_active, sync_bad, blank_bad, lock_sync_bad;

  // x/y hold the coordinate of the upcoming sample; cur_* is the coordinate assigned
  // to the sample being taken now, which in SEARCH is fixed by a vs fall.
  always_comb begin
    cur_x = x;
    cur_y = y;
    if (state == SEARCH) begin
      cur_x = '0;
      cur_y = vs_fall ? VS_F : '0;
    end

    in_active = (cur_x < H_ACT) && (cur_y < V_ACT);

    sync_bad = (hs_fall && (cur_x != HS_F)) ||
               (hs_rise && (cur_x != HS_R)) ||
               (vs_fall && ((cur_x != '0) || (cur_y != VS_F))) ||
               (vs_rise && ((cur_x != '0) || (cur_y != VS_R)));

    lock_sync_bad = (state == LOCKED) && sync_bad;
    blank_bad     = (state == LOCKED) && (bus.blank != in_active);

    state_nxt = state;
    case (state)
      SEARCH: if (vs_fall) state_nxt = VERIFY;
      VERIFY: begin
        if (sync_bad)     state_nxt = SEARCH;
        else if (vs_fall) state_nxt = LOCKED;
      end
      LOCKED: if (sync_bad) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase

    nxt_x = '0;
    nxt_y = '0;
    if (state_nxt != SEARCH) begin
      if (cur_x == H_LAST) begin
        nxt_y = (cur_y == V_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        nxt_x = cur_x + 1'b1;
        nxt_y = cur_y;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= SEARCH;
      x           <= '0;
      y           <= '0;
      RxX         <= '0;
      RxY         <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      blank_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      blank_err   <= 1'b0;
      if (bus.pix_en) begin
        state       <= state_nxt;
        x           <= nxt_x;
        y           <= nxt_y;
        RxX         <= cur_x;
        RxY         <= cur_y;
        locked      <= (state_nxt == LOCKED);
        active      <= (state_nxt == LOCKED) && in_active;
        frame_start <= (state == LOCKED) && (state_nxt == LOCKED) &&
                       (cur_x == '0) && (cur_y == '0);
        sync_err    <= lock_sync_bad;
        blank_err   <= blank_bad;
        if (lock_sync_bad || blank_bad)
          err_count <= sat_inc8(err_count);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives reduced-size VGA timing with a random pixel strobe and checks the decoder
// against a linear-position reference model of the lock/coordinate rules.
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HA  = 24;
  localparam int HSS = 28;
  localparam int HSL = 6;
  localparam int VT  = 20;
  localparam int VA  = 12;
  localparam int VSS = 14;
  localparam int VSL = 2;
  localparam int FRAME = HT * VT;

  logic clk;
  logic rst_n;
  logic [9:0] RxX, RxY;
  logic active, frame_start, locked, sync_err, blank_err;
  logic [7:0] err_count;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_TOTAL      (HT),
    .H_ACTIVE     (HA),
    .H_SYNC_START (HSS),
    .H_SYNC_LEN   (HSL),
    .V_TOTAL      (VT),
    .V_ACTIVE     (VA),
    .V_SYNC_START (VSS),
    .V_SYNC_LEN   (VSL)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .bus         (bus),
    .RxX         (RxX),
    .RxY         (RxY),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .blank_err   (blank_err),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Generator position (ground truth of what is on the bus).
  int gx = 0, gy = 0;
  bit gen_vf;

  // Reference model: mode 0 = hunting, 1 = checking a frame, 2 = trusted.
  int m_mode = 0;
  int m_pos  = 0;
  bit m_phs  = 1'b1, m_pvs = 1'b1;
  logic [9:0] e_x = '0, e_y = '0;
  logic e_act = 1'b0, e_fs = 1'b0, e_lock = 1'b0, e_serr = 1'b0, e_berr = 1'b0;
  logic [7:0] e_cnt = '0;

  logic [32:0] obs, exp_vec;
  assign obs     = {RxX, RxY, active, frame_start, locked, sync_err, blank_err, err_count};
  assign exp_vec = {e_x, e_y, e_act, e_fs, e_lock, e_serr, e_berr, e_cnt};

  function automatic bit rnd_en();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic step(input bit en, input bit hs_flip, input bit blank_flip);
    bit h, v, b, hf, hr, vf, vr, mism, vis;
    int cur, cx, cy, nmode;
    h = (!((gx >= HSS) && (gx < HSS + HSL))) ^ hs_flip;
    v = !((gy >= VSS) && (gy < VSS + VSL));
    b = ((gx < HA) && (gy < VA)) ^ blank_flip;
    bus.pix_en = en;
    bus.hs     = h;
    bus.vs     = v;
    bus.blank  = b;
    e_fs   = 1'b0;
    e_serr = 1'b0;
    e_berr = 1'b0;
    gen_vf = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_phs = 1'b1; m_pvs = 1'b1;
      e_x = '0; e_y = '0; e_act = 1'b0; e_lock = 1'b0; e_cnt = '0;
    end else if (en) begin
      hf = m_phs && !h;  hr = !m_phs && h;
      vf = m_pvs && !v;  vr = !m_pvs && v;
      gen_vf = vf;
      if (m_mode == 0) cur = vf ? VSS * HT : 0;
      else             cur = m_pos;
      cx = cur % HT;
      cy = cur / HT;
      vis = (cx < HA) && (cy < VA);
      mism = 1'b0;
      if (m_mode != 0)
        mism = (hf && cx != HSS) || (hr && cx != HSS + HSL) ||
               (vf && cur != VSS * HT) || (vr && cur != (VSS + VSL) * HT);
      if (m_mode != 0 && mism)   nmode = 0;
      else if (m_mode == 1 && vf) nmode = 2;
      else if (m_mode == 0 && vf) nmode = 1;
      else                        nmode = m_mode;
      e_serr = (m_mode == 2) && mism;
      e_berr = (m_mode == 2) && (b != vis);
      e_fs   = (m_mode == 2) && (nmode == 2) && (cur == 0);
      e_x    = 10'(cx);
      e_y    = 10'(cy);
      e_lock = (nmode == 2);
      e_act  = e_lock && vis;
      if ((e_serr || e_berr) && e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
      m_pos  = (nmode == 0) ? 0 : (cur + 1) % FRAME;
      m_mode = nmode;
      m_phs  = h;
      m_pvs  = v;
    end
    if (en) begin
      gx = gx + 1;
      if (gx == HT) begin
        gx = 0;
        gy = (gy + 1) % VT;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (obs !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs obs=%h exp=%h", obs, 33'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int vfalls = 0;
    int fs_seen = 0;
    int samples = 0;
    bit done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      if (gen_vf) vfalls++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL lock_seq obs=%h exp=%h", obs, exp_vec);
      end
      if (locked === 1'b1) begin
        done = 1'b1;
        n_tests++;
        if (!gen_vf || vfalls != 2) begin
          n_fail++;
          $display("FAIL lock_point vs_falls=%0d on_fall=%0d exp vs_falls=2 on_fall=1", vfalls, gen_vf);
        end
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL lock_timeout locked=%b exp=1", locked);
    end
    for (int i = 0; i < 5000 && samples < 2 * FRAME; i++) begin
      bit en;
      en = rnd_en();
      step(en, 1'b0, 1'b0);
      if (en) samples++;
      if (frame_start === 1'b1) fs_seen++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL frame_seq obs=%h exp=%h", obs, exp_vec);
      end
    end
    n_tests++;
    if (fs_seen != 2) begin
      n_fail++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_seen);
    end
  endtask

  task automatic test_hs_delay();
    int vfalls = 0;
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !(gx == HSS && gy == 3); i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL hs_pre obs=%h exp=%h", obs, exp_vec);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (sync_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_delay_err sync_err=%b err_count=%0d locked=%b exp 1/1/0",
               sync_err, err_count, locked);
    end
    step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_delay_pulse sync_err=%b exp=0", sync_err);
    end
    for (int i = 0; i < 6000 && !done; i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      if (gen_vf) vfalls++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL hs_relock_seq obs=%h exp=%h", obs, exp_vec);
      end
      if (locked === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done || vfalls != 2) begin
      n_fail++;
      $display("FAIL hs_relock locked=%b vs_falls=%0d exp locked=1 vs_falls=2", locked, vfalls);
    end
  endtask

  task automatic test_blank_err();
    for (int i = 0; i < 4000 && !(gx == 26 && gy == 5); i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL blank_pre obs=%h exp=%h", obs, exp_vec);
      end
    end
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (blank_err !== 1'b1 || sync_err !== 1'b0 || err_count !== 8'd2 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_err_hit blank_err=%b sync_err=%b err_count=%0d locked=%b exp 1/0/2/1",
               blank_err, sync_err, err_count, locked);
    end
    step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (blank_err !== 1'b0 || locked !== 1'b1 || obs !== exp_vec) begin
      n_fail++;
      $display("FAIL blank_err_after obs=%h exp=%h", obs, exp_vec);
    end
  endtask

  task automatic test_pix_en_hold();
    for (int i = 0; i < 4000 && !(gx == 10 && gy == 7); i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL hold_pre obs=%h exp=%h", obs, exp_vec);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (RxX !== 10'd10 || RxY !== 10'd7 || sync_err !== 1'b0 || blank_err !== 1'b0 ||
          frame_start !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL pix_en_hold RxX=%0d RxY=%0d serr=%b berr=%b fs=%b lock=%b exp 10/7/0/0/0/1",
                 RxX, RxY, sync_err, blank_err, frame_start, locked);
      end
    end
  endtask

  task automatic test_reset_mid();
    int vfalls = 0;
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !(gx == 15 && gy == 8); i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_pre obs=%h exp=%h", obs, exp_vec);
      end
    end
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    n_tests++;
    if (obs !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_mid obs=%h exp=%h", obs, 33'd0);
    end
    for (int i = 0; i < 6000 && !done; i++) begin
      step(rnd_en(), 1'b0, 1'b0);
      if (gen_vf) vfalls++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_relock_seq obs=%h exp=%h", obs, exp_vec);
      end
      if (locked === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done || vfalls != 2) begin
      n_fail++;
      $display("FAIL rstmid_relock locked=%b vs_falls=%0d exp locked=1 vs_falls=2", locked, vfalls);
    end
  endtask

  task automatic test_saturate();
    int flips = 0;
    for (int i = 0; i < 2000 && flips < 300; i++) begin
      bit en;
      en = rnd_en();
      step(en, 1'b0, en);
      if (en) flips++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL sat_seq obs=%h exp=%h", obs, exp_vec);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (err_count !== 8'd255 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL err_saturate err_count=%0d locked=%b exp 255/1", err_count, locked);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.pix_en = 1'b0;
    bus.hs = 1'b1;
    bus.vs = 1'b1;
    bus.blank = 1'b0;
    test_reset();
    test_lock();
    test_hs_delay();
    test_blank_err();
    test_pix_en_hold();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
